// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch has priority, CPU gets a forced slot after a
// bounded display streak; read data is routed back by a 2-stage owner tag pipeline.
//
// state  | meaning
// C_IDLE | no CPU op outstanding, CPU may be granted
// C_WR   | CPU write issued to RAM, ack at next edge
// C_RD1  | CPU read issued, RAM sampling address
// C_RD2  | CPU read data on mem_rdata, ack and capture at next edge
module vga_fb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DISP_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WR   = 2'd1;
  localparam logic [1:0] C_RD1  = 2'd2;
  localparam logic [1:0] C_RD2  = 2'd3;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_DISP = 2'd1;
  localparam logic [1:0] T_CPU  = 2'd2;

  localparam int SW = (DISP_BURST < 1) ? 1 : $clog2(DISP_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DISP_BURST);
  localparam logic BURST_EN = (DISP_BURST > 0);

  logic [1:0]        cpu_state_q, cpu_state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [1:0]        tag1_q, tag1_d, tag2_q, tag2_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic cpu_elig, force_cpu, disp_win, cpu_win;

  always_comb begin
    cpu_elig  = cpu_req && (cpu_state_q == C_IDLE);
    force_cpu = BURST_EN && (streak_q == STREAK_MAX);
    disp_win  = disp_req && !(cpu_elig && force_cpu);
    cpu_win   = cpu_elig && !disp_win;
  end

  assign disp_gnt = disp_win && !reset;

  always_comb begin
    // streak only counts display wins that actually made the CPU wait
    streak_d = streak_q;
    if (!cpu_elig || cpu_win)
      streak_d = '0;
    else if (disp_win && (streak_q != STREAK_MAX))
      streak_d = streak_q + 1'b1;

    mem_en_d    = disp_win || cpu_win;
    mem_we_d    = cpu_win && cpu_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_win)
      mem_addr_d = disp_addr;
    else if (cpu_win)
      mem_addr_d = cpu_addr;
    if (cpu_win && cpu_we)
      mem_wdata_d = cpu_wdata;

    tag1_d = T_NONE;
    if (disp_win)
      tag1_d = T_DISP;
    else if (cpu_win && !cpu_we)
      tag1_d = T_CPU;
    tag2_d = tag1_q;

    disp_valid_d = (tag2_q == T_DISP);
    disp_data_d  = (tag2_q == T_DISP) ? mem_rdata : disp_data_q;
    cpu_rdata_d  = (tag2_q == T_CPU) ? mem_rdata : cpu_rdata_q;

    cpu_state_d = cpu_state_q;
    cpu_ack_d   = 1'b0;
    case (cpu_state_q)
      C_IDLE: if (cpu_win) cpu_state_d = cpu_we ? C_WR : C_RD1;
      C_WR: begin
        cpu_state_d = C_IDLE;
        cpu_ack_d   = 1'b1;
      end
      C_RD1: cpu_state_d = C_RD2;
      C_RD2: begin
        cpu_state_d = C_IDLE;
        cpu_ack_d   = 1'b1;
      end
      default: cpu_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state_q  <= C_IDLE;
      streak_q     <= '0;
      tag1_q       <= T_NONE;
      tag2_q       <= T_NONE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      cpu_state_q  <= cpu_state_d;
      streak_q     <= streak_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: main instance (DISP_BURST=8) with a RAM model,
// plus a DISP_BURST=0 instance for the strict-priority case.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] disp_addr = '0, cpu_addr = '0, cpu_wdata = '0;
  logic        disp_gnt, disp_valid, cpu_ack, mem_en, mem_we;
  logic [15:0] disp_data, cpu_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic        b_disp_req = 1'b0, b_cpu_req = 1'b0, b_cpu_we = 1'b0;
  logic [15:0] b_disp_addr = '0, b_cpu_addr = '0, b_cpu_wdata = '0;
  logic        b_disp_gnt, b_disp_valid, b_cpu_ack, b_mem_en, b_mem_we;
  logic [15:0] b_disp_data, b_cpu_rdata, b_mem_addr, b_mem_wdata;
  logic [15:0] b_mem_rdata = '0;

  logic [15:0] ram [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.ADDR_W(16), .DATA_W(16), .DISP_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  vga_fb_arbiter #(.ADDR_W(16), .DATA_W(16), .DISP_BURST(0)) dut0 (
    .clk(clk), .reset(reset),
    .disp_req(b_disp_req), .disp_addr(b_disp_addr), .disp_gnt(b_disp_gnt),
    .disp_valid(b_disp_valid), .disp_data(b_disp_data),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // single-port synchronous RAM: read data appears the cycle after mem_en is sampled
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'(a) ^ 16'hA5A5;

    // reset with both requesters active
    disp_req = 1'b1; disp_addr = 16'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0060;
    tick(); tick();
    chk("rst_disp_gnt", 32'(disp_gnt), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    #1;
    chk("first_gnt_disp", 32'(disp_gnt), 32'd1);
    tick();
    chk("first_mem_en", 32'(mem_en), 32'd1);
    chk("first_mem_we", 32'(mem_we), 32'd0);
    chk("first_mem_addr", 32'(mem_addr), 32'h0200);
    chk("first_cpu_state", 32'(dut.cpu_state_q), 32'd0);
    disp_req = 1'b0; cpu_req = 1'b0;
    tick();
    chk("first_valid_early", 32'(disp_valid), 32'd0);
    tick();
    chk("first_valid", 32'(disp_valid), 32'd1);
    chk("first_data", 32'(disp_data), 32'hA7A5);

    // display-only burst 0x0100..0x0104
    for (int c = 0; c < 7; c++) begin
      disp_req = (c < 5);
      disp_addr = 16'h0100 + 16'(c);
      #1;
      chk("burst_gnt", 32'(disp_gnt), (c < 5) ? 32'd1 : 32'd0);
      tick();
      if (c >= 2) begin
        chk("burst_valid", 32'(disp_valid), 32'd1);
        chk("burst_data", 32'(disp_data), 32'((16'h0100 + 16'(c - 2)) ^ 16'hA5A5));
      end else begin
        chk("burst_valid_lat", 32'(disp_valid), 32'd0);
      end
    end
    tick();
    chk("burst_valid_end", 32'(disp_valid), 32'd0);
    chk("burst_data_hold", 32'(disp_data), 32'hA4A1);

    // continuous display with a pending CPU write: 8 display slots, then the CPU
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'h1234;
    disp_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp_addr = 16'h0300 + 16'(i);
      #1;
      chk("streak_gnt", 32'(disp_gnt), 32'd1);
      tick();
      chk("streak_mem_en", 32'(mem_en), 32'd1);
      chk("streak_mem_we", 32'(mem_we), 32'd0);
      chk("streak_mem_addr", 32'(mem_addr), 32'h0300 + 32'(i));
    end
    disp_addr = 16'h0308;
    #1;
    chk("forced_no_disp_gnt", 32'(disp_gnt), 32'd0);
    tick();
    chk("wr_mem_en", 32'(mem_en), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h0050);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_ack_early", 32'(cpu_ack), 32'd0);
    chk("wr_resume_gnt", 32'(disp_gnt), 32'd1);
    tick();
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    chk("wr_resume_en", 32'(mem_en), 32'd1);
    chk("wr_resume_we", 32'(mem_we), 32'd0);
    chk("wr_resume_addr", 32'(mem_addr), 32'h0308);
    cpu_req = 1'b0; disp_req = 1'b0;
    tick();
    chk("wr_ack_pulse", 32'(cpu_ack), 32'd0);
    tick(); tick(); tick();

    // CPU read of 0x0050 with display idle, request held through the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    #1;
    chk("rd_no_disp_gnt", 32'(disp_gnt), 32'd0);
    tick();
    chk("rd_mem_en", 32'(mem_en), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0050);
    chk("rd_ack_k", 32'(cpu_ack), 32'd0);
    tick();
    chk("rd1_no_regrant", 32'(mem_en), 32'd0);
    chk("rd1_addr_hold", 32'(mem_addr), 32'h0050);
    chk("rd_ack_k1", 32'(cpu_ack), 32'd0);
    tick();
    chk("rd2_no_regrant", 32'(mem_en), 32'd0);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'h1234);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    chk("rd_rdata_hold", 32'(cpu_rdata), 32'h1234);
    chk("rd_idle_en", 32'(mem_en), 32'd0);

    // strict display priority instance
    b_disp_req = 1'b1; b_disp_addr = 16'h0400;
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 16'h0070; b_cpu_wdata = 16'hBEEF;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("strict_gnt", 32'(b_disp_gnt), 32'd1);
      tick();
      chk("strict_no_cpu", 32'(b_mem_we), 32'd0);
    end
    b_disp_req = 1'b0;
    #1;
    chk("strict_gnt_drop", 32'(b_disp_gnt), 32'd0);
    tick();
    chk("strict_cpu_en", 32'(b_mem_en), 32'd1);
    chk("strict_cpu_we", 32'(b_mem_we), 32'd1);
    chk("strict_cpu_addr", 32'(b_mem_addr), 32'h0070);
    chk("strict_cpu_wdata", 32'(b_mem_wdata), 32'hBEEF);
    b_cpu_req = 1'b0;
    tick();
    chk("strict_ack", 32'(b_cpu_ack), 32'd1);

    // reset with a display read and a CPU read in flight
    disp_req = 1'b1; disp_addr = 16'h0500;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    tick();
    chk("inflt_disp_addr", 32'(mem_addr), 32'h0500);
    disp_req = 1'b0;
    tick();
    chk("inflt_cpu_en", 32'(mem_en), 32'd1);
    chk("inflt_cpu_addr", 32'(mem_addr), 32'h0050);
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("inflt_no_valid", 32'(disp_valid), 32'd0);
      chk("inflt_no_ack", 32'(cpu_ack), 32'd0);
      tick();
    end
    chk("inflt_state_idle", 32'(dut.cpu_state_q), 32'd0);
    chk("inflt_streak_zero", 32'(dut.streak_q), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0051; cpu_wdata = 16'h0F0F;
    tick();
    chk("post_rst_cpu_we", 32'(mem_we), 32'd1);
    chk("post_rst_cpu_addr", 32'(mem_addr), 32'h0051);
    cpu_req = 1'b0;
    tick();
    chk("post_rst_ack", 32'(cpu_ack), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters.
- The display fetch path reads pixels ahead of the VGA scan-out.
- The CPU/bus port reads and writes the framebuffer.
- Display has priority, but a bounded-streak rule guarantees CPU progress. The block tags every RAM read so returned data is routed to the requester that issued it.

Parameters:
ADDR_W, 16, framebuffer word address width
DATA_W, 16, framebuffer word width
DISP_BURST, 8, max consecutive display grants while CPU is pending before CPU is forced one slot; 0 = strict display priority (no forced slots)

Ports:
clk  in  1  system clock (25 MHz pixel domain)
reset  in  1  synchronous, active-high
disp_req  in  1  display wants a read this cycle (level)
disp_addr  in  ADDR_W  display read address, valid with disp_req
disp_gnt  out  1  display request accepted at this edge; source advances address
disp_valid  out  1  one-cycle pulse, disp_data valid
disp_data  out  DATA_W  display read data
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
cpu_ack  out  1  one-cycle pulse, CPU op complete
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid one cycle after the edge where RAM samples mem_en

Behaviour:
- Reset (synchronous): every output is 0; streak counter = 0; CPU state = C_IDLE; read-return pipeline tags cleared. In-flight reads are discarded and produce no valid/ack.
- Arbitration happens at each posedge. Eligible requesters:
  - Display is eligible when disp_req = 1.
  - CPU is eligible when cpu_req = 1 and the CPU state is C_IDLE.
- Winner selection:
  - Only one eligible: that one wins.
  - Both eligible: display wins, unless DISP_BURST > 0 and streak == DISP_BURST, in which case CPU wins.
- Streak counter:
  - Increments on a display grant while CPU is eligible.
  - Clears on a CPU grant, or in any cycle where CPU is not eligible.
  - Saturates at DISP_BURST.
- On a grant at edge k, mem_en/mem_we/mem_addr/mem_wdata are registered for cycle k..k+1.
  - With no grant: mem_en = 0 and mem_we = 0; the address and data hold their last value.
- disp_gnt is combinational and high in the cycle before edge k when display will win. Downstream samples disp_gnt together with disp_req at edge k.
- Read return pipeline:
  - A 2-stage tag shift register (owner: none/disp/cpu) tracks each read.
  - RAM samples the request at k+1; mem_rdata is captured at k+2.
  - Display read: disp_valid = 1 and disp_data registered for cycle k+2..k+3. Latency is 2 clocks from the grant edge.
  - CPU read: cpu_ack = 1 and cpu_rdata registered in the same cycle (k+2..k+3).
  - Back-to-back display grants yield back-to-back disp_valid pulses, one per clock, in order.
- CPU write: cpu_ack = 1 in cycle k+1..k+2. mem_we = 1 only in cycle k..k+1.
- CPU state machine:
  - C_IDLE → C_WR on a write grant; C_WR → C_IDLE at the next edge (ack issued).
  - C_IDLE → C_RD1 on a read grant; C_RD1 → C_RD2 → C_IDLE (ack at C_RD2 exit).
  - CPU is not eligible outside C_IDLE, so at most one CPU op is outstanding.
- cpu_req sampled high in the cycle cpu_ack is high is treated as a new request only once the state is back in C_IDLE; the CPU must deassert or present the next op after the ack.
- disp_req dropping mid-stream: in-flight reads still return. No display grant without disp_req.
- cpu_rdata holds its value between acks; disp_data holds its value between valids.

Test Plan:
- Reset with disp_req = 1 and cpu_req = 1 asserted → all outputs 0 during reset. First grant goes to display at the first edge after reset deasserts; mem_addr = disp_addr.
- Display only, disp_addr 0x0100..0x0104 on consecutive clocks, RAM preloaded data = addr^0xA5A5 → five disp_valid pulses on consecutive clocks starting 2 clocks after the first grant, data 0xA4A5, 0xA4A4, 0xA4A7, 0xA4A6, 0xA4A1.
- Continuous disp_req plus CPU write 0x1234 to 0x0050, DISP_BURST = 8 → exactly 8 display grants, then one cycle with mem_we = 1, mem_addr = 0x0050, mem_wdata = 0x1234. cpu_ack follows 1 clock later; display grants resume on the next edge.
- CPU read of 0x0050 after that write, display idle → mem_en one cycle; cpu_ack with cpu_rdata = 0x1234 exactly 2 clocks after the grant. No new CPU grant while in C_RD1/C_RD2, even with cpu_req held.
- DISP_BURST = 0 with continuous disp_req and a pending CPU op → CPU is never granted. Drop disp_req for one cycle → CPU is granted at that edge.
- Assert reset in the cycle after a display and a CPU read grant → no disp_valid and no cpu_ack emerge; state returns to C_IDLE and the streak counter is 0.
